// File: rtl/pe_inject_queue_if.sv
// rtl/pe_inject_queue_if.sv - PE-to-router flit handshake bundle for the injection queue
interface pe_inject_queue_if #(
  parameter int DataWidth = 40
);
  logic [DataWidth-1:0] i_data;
  logic                 i_data_valid;
  logic                 o_data_ready;
  logic [DataWidth-1:0] o_data;
  logic                 o_data_valid;
  logic                 i_data_ready;

  // Traffic side: drives the PE flit and the router ready.
  modport master (
    output i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid
  );

  // Queue side.
  modport slave (
    input  i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid
  );
endinterface

// File: rtl/pe_inject_queue.sv
// rtl/pe_inject_queue.sv - FWFT injection queue with dest filtering and traffic statistics
module pe_inject_queue #(
  parameter int DataWidth    = 40,
  parameter int AddressWidth = 5,
  parameter int numPE        = 32,
  parameter int Depth        = 8,
  parameter int CntWidth     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_inject_queue_if.slave         bus,
  output logic [CntWidth-1:0]      o_sent_count,
  output logic [CntWidth-1:0]      o_drop_count,
  output logic [$clog2(Depth):0]   o_high_water
);
  localparam int PtrW = $clog2(Depth);
  localparam int OccW = PtrW + 1;
  localparam logic [AddressWidth:0] NumPeL = (AddressWidth + 1)'(numPE);

  logic [DataWidth-1:0]    mem [Depth];
  logic [PtrW-1:0]         wr_ptr;
  logic [PtrW-1:0]         rd_ptr;
  logic [PtrW-1:0]         rd_ptr_inc;
  logic [OccW-1:0]         occ;
  logic [OccW-1:0]         occ_next;
  logic [DataWidth-1:0]    head_q;
  logic [DataWidth-1:0]    head_next;
  logic [AddressWidth-1:0] dest;
  logic                    push;
  logic                    pop;
  logic                    legal;
  logic                    wr_en;

  assign dest       = bus.i_data[32+AddressWidth:33];
  // A flit is only worth queueing if its valid bit is set and it targets a real PE.
  assign legal      = bus.i_data[DataWidth-1] & ({1'b0, dest} < NumPeL);
  // Router ready passes straight through so a full queue can still swap a flit per cycle.
  assign bus.o_data_ready = (occ < OccW'(Depth)) | bus.i_data_ready;
  assign bus.o_data_valid = (occ != '0);
  assign bus.o_data       = head_q;
  assign push       = bus.i_data_valid & bus.o_data_ready;
  assign pop        = bus.o_data_valid & bus.i_data_ready;
  assign wr_en      = push & legal;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Occupancy moves only when exactly one of a kept push or a pop happens.
  always_comb begin
    occ_next = occ;
    if (wr_en && !pop) begin
      occ_next = occ + 1'b1;
    end else if (!wr_en && pop) begin
      occ_next = occ - 1'b1;
    end
  end

  // Next head: the entry behind the popped one, or the incoming flit when the queue runs dry.
  always_comb begin
    head_next = head_q;
    if (pop && (occ > OccW'(1))) begin
      head_next = mem[rd_ptr_inc];
    end else if (wr_en && ((occ == '0) || (pop && (occ == OccW'(1))))) begin
      head_next = bus.i_data;
    end
  end

  // Storage array holds every queued flit, head included; it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  // Pointers, occupancy, registered head and saturating statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      head_q       <= '0;
      o_sent_count <= '0;
      o_drop_count <= '0;
      o_high_water <= '0;
    end else begin
      occ    <= occ_next;
      head_q <= head_next;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (pop && (o_sent_count != '1)) begin
        o_sent_count <= o_sent_count + 1'b1;
      end
      if (push && !legal && (o_drop_count != '1)) begin
        o_drop_count <= o_drop_count + 1'b1;
      end
      if (occ_next > o_high_water) begin
        o_high_water <= occ_next;
      end
    end
  end
endmodule

// File: doc/pe_inject_queue.md
Name: pe_inject_queue

Overview:
- Injection-side network interface between a PE traffic source and its local router input port in the torus NoC.
- Accepts 40-bit flits from the PE over valid/ready and buffers them in a first-word-fall-through FIFO.
- Drops flits whose destination is outside the PE range, and presents flits to the router over valid/ready.
- Keeps sent, dropped and high-water statistics for the end-of-run report.

Parameters:
- DataWidth, 40, flit width; layout {vld, hdr, dest[AddressWidth-1:0], rsv, payload[31:0]}, so DataWidth = AddressWidth+35.
- AddressWidth, 5, destination field width; dest occupies bits [32+AddressWidth:33].
- numPE, 32, number of valid PE addresses; dest >= numPE is illegal.
- Depth, 8, FIFO entries; power of two, >= 2.
- CntWidth, 16, width of the statistic counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_data  input  DataWidth  flit from PE.
- i_data_valid  input  1  PE flit valid.
- o_data_ready  output  1  queue can accept a flit.
- o_data  output  DataWidth  flit to router; head of FIFO.
- o_data_valid  output  1  head flit valid.
- i_data_ready  input  1  router accepts the head flit.
- o_sent_count  output  CntWidth  flits delivered to router.
- o_drop_count  output  CntWidth  flits dropped for illegal dest.
- o_high_water  output  log2(Depth)+1  maximum occupancy since reset.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, read/write pointers 0, occupancy 0, o_data_valid 0, o_data 0, o_data_ready 1, all counters 0. Reset asserted mid-transfer discards all queued flits; no partial flit survives.
- Push occurs when i_data_valid & o_data_ready at a clock edge.
- Pop occurs when o_data_valid & i_data_ready at a clock edge.
- o_data_ready = (occupancy < Depth) | i_data_ready. This is a combinational pass-through of router ready, so a push and a pop can both happen on a full queue.
- Legality check on push: dest = i_data[32+AddressWidth:33].
  - If dest >= numPE: the flit is not written, o_drop_count increments (saturating at all-ones), and the handshake still completes (o_data_ready is honoured).
  - Flits with i_data[DataWidth-1] = 0 are treated the same as illegal and dropped.
- FWFT output:
  - o_data and o_data_valid are registered.
  - A legal flit pushed into an empty queue appears on o_data one cycle after the push edge.
  - Head is updated on the same edge as a pop when occupancy > 1.
  - o_data_valid = (occupancy > 0). o_data holds its value while valid & !ready; it must not change until popped.
  - When the queue is empty, o_data holds its last value but is don't-care.
- Occupancy next value:
  - +1 on legal push without pop.
  - -1 on pop without legal push.
  - Unchanged on both, or neither.
- Pointer wrap: pointers are log2(Depth) bits and wrap modulo Depth. Full/empty are derived from occupancy, not pointer equality.
- Statistics:
  - o_sent_count increments on each pop, saturating.
  - o_high_water updates to the new occupancy whenever that exceeds the current value.
- Ordering: legal flits leave in arrival order; payload bits are unmodified.
- Latency: 1 cycle from push to o_data_valid when empty and the router is ready; one flit per cycle sustained throughput.

Test Plan:
- Reset, then push one flit 0xC3_0000_0005 (dest 1) with router ready held high → o_data_valid 1 exactly one cycle later with o_data = 0xC3_0000_0005; o_sent_count = 1 after pop.
- Hold i_data_ready = 0 and push 8 legal flits with payloads 0..7 → o_data_ready drops to 0 after the 8th; o_high_water = 8. Then release ready → payloads 0..7 emerge in order on consecutive cycles.
- With the queue full and i_data_ready = 1, push on the same cycle as a pop → occupancy stays 8, no flit lost, new flit appears as the 9th output.
- With numPE = 20, push dest 25 and then dest 19 → o_drop_count = 1; only the dest-19 flit reaches o_data.
- Drive rst low asynchronously (between clock edges) with 5 flits queued → o_data_valid falls immediately; counters 0, high-water 0. After release, the first new flit is delivered with 1-cycle latency.
- Random traffic of 1000 flits with random i_data_ready (50%) → scoreboard order matches; o_sent_count + o_drop_count = 1000; occupancy never exceeds 8.
